// File: rtl/debug_dma_cmd_issue_pkg.sv
// Shared types for the debug DMA command issue path: host request,
// DMA register-write interface and the register images it carries.
package debug_dma_cmd_issue_pkg;

    localparam int DBG_NTHREAD      = 8;
    localparam int DBG_NTHREADIDMSB = 2;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef enum logic [1:0] {
        DMA_NOP  = 2'd0,
        DMA_OP   = 2'd1,
        DMA_FILL = 2'd2,
        DMA_CLR  = 2'd3
    } debug_dma_cmd_e;

    typedef logic [DBG_NTHREADIDMSB:0] dbg_tid_t;

    typedef struct packed {
        dbg_tid_t       tid;
        logic [31:0]    addr;
        logic [31:0]    buf_addr;
        logic [15:0]    count;
        debug_dma_cmd_e cmd;
    } debug_host_dma_req_type;

    typedef struct packed {
        logic [31:0] addr;
        logic        parity;
    } debug_dma_addr_reg_type;

    typedef struct packed {
        logic [31:0]    buf_addr;
        logic [15:0]    count;
        debug_dma_cmd_e cmd;
        logic           parity;
    } debug_dma_ctrl_reg_type;

    typedef struct packed {
        dbg_tid_t               tid;
        logic                   addr_we;
        debug_dma_addr_reg_type addr_reg;
        logic                   ctrl_we;
        debug_dma_ctrl_reg_type ctrl_reg;
    } debug_dma_cmdif_in_type;

    // Parity bits are only populated when the LUTRAM protection option is on.
    function automatic debug_dma_addr_reg_type addr_reg_pack(input logic [31:0] addr,
                                                             input logic prot);
        return '{addr: addr, parity: prot & (^addr)};
    endfunction

    function automatic debug_dma_ctrl_reg_type ctrl_reg_pack(input logic [31:0] buf_addr,
                                                             input logic [15:0] count,
                                                             input debug_dma_cmd_e cmd,
                                                             input logic prot);
        return '{buf_addr: buf_addr, count: count, cmd: cmd,
                 parity: prot & (^{buf_addr, count, cmd})};
    endfunction

endpackage

// File: rtl/debug_dma_done_arb.sv
// Completion store: per-thread done flags, lowest-index pick, and the host
// response handshake with the chosen tid frozen while the host stalls.
module debug_dma_done_arb
    import debug_dma_cmd_issue_pkg::*;
#(
    parameter int NTHREAD      = DBG_NTHREAD,
    parameter int NTHREADIDMSB = DBG_NTHREADIDMSB
) (
    input  iu_clk_type              gclk,
    input  logic                    rst,
    input  logic [NTHREAD-1:0]      i_set_vec,
    output logic [NTHREAD-1:0]      o_done_vec,
    output logic                    o_rsp_valid,
    output logic [NTHREADIDMSB:0]   o_rsp_tid,
    input  logic                    i_rsp_ready
);

    logic [NTHREAD-1:0]    r_done;
    logic                  r_hold;
    logic [NTHREADIDMSB:0] r_hold_tid;
    logic [NTHREADIDMSB:0] w_lowest;
    logic [NTHREAD-1:0]    w_clr;
    logic                  w_hs;

    always_comb begin
        w_lowest = '0;
        for (int i = NTHREAD - 1; i >= 0; i--) begin
            if (r_done[i]) w_lowest = (NTHREADIDMSB + 1)'(i);
        end
    end

    // A lower tid finishing during a stall must not change the offered tid.
    assign o_rsp_valid = ~rst & (|r_done);
    assign o_rsp_tid   = r_hold ? r_hold_tid : w_lowest;
    assign o_done_vec  = r_done;
    assign w_hs        = o_rsp_valid & i_rsp_ready;

    always_comb begin
        w_clr = '0;
        if (w_hs) w_clr[o_rsp_tid] = 1'b1;
    end

    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            r_done     <= '0;
            r_hold     <= 1'b0;
            r_hold_tid <= '0;
        end else begin
            r_done     <= (r_done & ~w_clr) | i_set_vec;
            r_hold     <= o_rsp_valid & ~i_rsp_ready;
            r_hold_tid <= o_rsp_tid;
        end
    end

endmodule

// File: rtl/debug_dma_cmd_issue.sv
// Turns host DMA requests into an addr-then-ctrl register write sequence to
// the DMA engine and tracks per-thread in-flight / completed state.
module debug_dma_cmd_issue
    import debug_dma_cmd_issue_pkg::*;
#(
    parameter int NTHREAD      = DBG_NTHREAD,
    parameter int NTHREADIDMSB = DBG_NTHREADIDMSB,
    parameter bit LUTRAMPROT   = 1'b1
) (
    input  iu_clk_type              gclk,
    input  logic                    rst,
    input  logic                    host_req_valid,
    input  debug_host_dma_req_type  host_req,
    output logic                    host_req_ready,
    output debug_dma_cmdif_in_type  dma_cmd_out,
    input  logic                    dma_cmd_ack,
    input  logic                    dma_done,
    input  logic [NTHREADIDMSB:0]   dma_done_tid,
    output logic                    host_rsp_valid,
    output logic [NTHREADIDMSB:0]   host_rsp_tid,
    input  logic                    host_rsp_ready,
    output logic [NTHREAD-1:0]      busy_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WADDR = 2'd1,
        S_WCTRL = 2'd2
    } state_e;

    state_e                 r_state;
    debug_host_dma_req_type r_req;
    logic                   r_addr_we;
    logic                   r_ctrl_we;
    logic                   r_zc_vld;
    logic [NTHREAD-1:0]     r_busy;
    logic                   r_spurious_done;

    logic [NTHREAD-1:0]     w_done_vec;
    logic [NTHREAD-1:0]     w_done_set;
    logic                   w_req_blocked;
    logic                   w_accept;
    logic                   w_ack;
    logic                   w_done_hit;
    logic                   w_spurious_unused;

    // A zero-count accept lands in done_vec one cycle late; block that tid meanwhile.
    assign w_req_blocked  = r_busy[host_req.tid] | w_done_vec[host_req.tid]
                          | (r_zc_vld & (r_req.tid == host_req.tid));
    assign host_req_ready = ~rst & (r_state == S_IDLE) & ~w_req_blocked;
    assign w_accept       = host_req_valid & host_req_ready;
    assign w_ack          = r_ctrl_we & dma_cmd_ack;
    assign w_done_hit     = dma_done & r_busy[dma_done_tid];

    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr_we <= 1'b0;
            r_ctrl_we <= 1'b0;
            r_zc_vld  <= 1'b0;
            r_req     <= '0;
        end else begin
            r_zc_vld <= 1'b0;
            if (w_accept) r_req <= host_req;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (host_req.count != '0) begin
                            r_state   <= S_WADDR;
                            r_addr_we <= 1'b1;
                        end else begin
                            r_zc_vld  <= 1'b1;
                        end
                    end
                end
                S_WADDR: begin
                    r_state   <= S_WCTRL;
                    r_addr_we <= 1'b0;
                    r_ctrl_we <= 1'b1;
                end
                S_WCTRL: begin
                    if (dma_cmd_ack) begin
                        r_state   <= S_IDLE;
                        r_ctrl_we <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_addr_we <= 1'b0;
                    r_ctrl_we <= 1'b0;
                end
            endcase
        end
    end

    // Ack set comes after the done clear so the set wins on a same-tid collision.
    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            r_busy          <= '0;
            r_spurious_done <= 1'b0;
        end else begin
            if (w_done_hit) r_busy[dma_done_tid] <= 1'b0;
            if (w_ack)      r_busy[r_req.tid]    <= 1'b1;
            if (dma_done & ~r_busy[dma_done_tid]) r_spurious_done <= 1'b1;
        end
    end

    // Sticky flag has no port; it is read only through hierarchical debug probes.
    assign w_spurious_unused = r_spurious_done;

    always_comb begin
        w_done_set = '0;
        if (w_done_hit) w_done_set[dma_done_tid] = 1'b1;
        if (r_zc_vld)   w_done_set[r_req.tid]    = 1'b1;
    end

    debug_dma_done_arb #(
        .NTHREAD      (NTHREAD),
        .NTHREADIDMSB (NTHREADIDMSB)
    ) u_done_arb (
        .gclk        (gclk),
        .rst         (rst),
        .i_set_vec   (w_done_set),
        .o_done_vec  (w_done_vec),
        .o_rsp_valid (host_rsp_valid),
        .o_rsp_tid   (host_rsp_tid),
        .i_rsp_ready (host_rsp_ready)
    );

    always_comb begin
        dma_cmd_out          = '0;
        dma_cmd_out.tid      = r_req.tid;
        dma_cmd_out.addr_we  = r_addr_we & ~rst;
        dma_cmd_out.addr_reg = addr_reg_pack(r_req.addr, LUTRAMPROT);
        dma_cmd_out.ctrl_we  = r_ctrl_we & ~rst;
        dma_cmd_out.ctrl_reg = ctrl_reg_pack(r_req.buf_addr, r_req.count, r_req.cmd, LUTRAMPROT);
    end

    assign busy_vec = rst ? '0 : r_busy;

endmodule

// File: doc/debug_dma_cmd_issue.md
DEBUG_DMA_CMD_ISSUE -- requirements
Module: debug_dma_cmd_issue

Interface
REQ-001 SHALL have parameters from libconf/libiu: NTHREAD (thread count), NTHREADIDMSB (thread-ID MSB), LUTRAMPROT (parity enable, 0/1).
REQ-002 gclk  input  iu_clk_type  clock; all state updates on posedge gclk.clk only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 host_req_valid  input  1  host DMA request valid.
REQ-005 host_req  input  debug_host_dma_req_type  request fields: tid, addr[31:0], buf_addr, count, cmd.
REQ-006 host_req_ready  output  1  request accepted when valid & ready.
REQ-007 dma_cmd_out  output  debug_dma_cmdif_in_type  register-write port: tid, addr_we, addr_reg, ctrl_we, ctrl_reg.
REQ-008 dma_cmd_ack  input  1  DMA engine accepted the ctrl register write this cycle.
REQ-009 dma_done  input  1  one-cycle pulse: a thread finished its transfer.
REQ-010 dma_done_tid  input  NTHREADIDMSB+1  thread ID qualifying dma_done.
REQ-011 host_rsp_valid  output  1  completion available.
REQ-012 host_rsp_tid  output  NTHREADIDMSB+1  completed thread ID.
REQ-013 host_rsp_ready  input  1  completion consumed when valid & ready.
REQ-014 busy_vec  output  NTHREAD  per-thread DMA-in-flight flags.

Function
REQ-015 SHALL implement FSM IDLE -> WADDR -> WCTRL -> IDLE.
REQ-016 In IDLE, host_req_ready SHALL be 1 iff busy_vec[host_req.tid]=0 and done_vec[host_req.tid]=0; otherwise stall, with no reordering.
REQ-017 On an accept with count!=0, the request SHALL be latched and the FSM SHALL enter WADDR.
REQ-018 On an accept with count=0, the block SHALL set done_vec[tid] in the next cycle, perform no register writes, and remain in IDLE.
REQ-019 WADDR SHALL assert addr_we for exactly one cycle with addr_reg.addr=latched addr and parity=^addr when LUTRAMPROT=1, else 0; it then enters WCTRL.
REQ-020 WCTRL SHALL assert ctrl_we with ctrl_reg = {buf_addr, count, cmd, parity}, where parity=^(other fields) when LUTRAMPROT=1, else 0.
REQ-021 ctrl_we SHALL be held until dma_cmd_ack=1; that same cycle the FSM SHALL set busy_vec[tid] and return to IDLE.
REQ-022 Request-to-ctrl_we latency SHALL be 2 cycles; the next accept SHALL be possible in the cycle after the ack.
REQ-023 addr_we and ctrl_we SHALL never be asserted in the same cycle; dma_cmd_out.tid SHALL be stable from WADDR through the ack.
REQ-024 dma_done SHALL clear busy_vec[dma_done_tid] and set done_vec[dma_done_tid].
REQ-025 dma_done for a non-busy tid SHALL be ignored and SHALL set sticky output-free flag spurious_done (debug-visible internal register).
REQ-026 host_rsp_valid SHALL be |done_vec; host_rsp_tid SHALL be the lowest set index and be held stable while valid & !ready.
REQ-027 On a response handshake the block SHALL clear that done_vec bit; a simultaneous dma_done for a different tid SHALL still be recorded.
REQ-028 A dma_done in the same cycle as a ctrl ack to the same tid SHALL NOT occur; if it does, the set of busy_vec SHALL win.

Reset
REQ-029 rst SHALL force FSM=IDLE, busy_vec=0, done_vec=0, spurious_done=0, addr_we=0, ctrl_we=0, host_rsp_valid=0 and host_req_ready=0 in the rst cycle; ready is evaluated normally from the next cycle.
REQ-030 rst mid-WADDR/WCTRL SHALL abandon the request with no further writes; the DMA engine clears its own ctrl regs on the same rst.

Structure
REQ-031 debug_host_dma_req_type SHALL be defined in libdebug alongside debug_dma_cmdif_in_type and the ctrl/addr reg types; FSM state enum is local.
REQ-032 SHALL use one sub-module debug_dma_done_arb: done_vec storage plus lowest-index priority encoder and handshake.

Verification
REQ-033 Request tid=3, addr=0x1000, buf_addr=5, count=8, cmd=dma_OP, ack immediate -> addr_we in cycle+1 with addr 0x1000; ctrl_we in cycle+2; busy_vec[3]=1.
REQ-034 Hold dma_cmd_ack=0 for 4 cycles in WCTRL -> ctrl_we held 4+1 cycles with fields stable; host_req_ready=0 throughout.
REQ-035 Request tid=2 while busy_vec[2]=1 -> ready=0 until dma_done(tid=2) and the response handshake; then accepted.
REQ-036 dma_done tid=1 and tid=4 in consecutive cycles, host_rsp_ready=0 for 3 cycles, then 1 -> responses tid=1 then tid=4, no loss.
REQ-037 count=0 request tid=6 -> no addr_we/ctrl_we; host_rsp_valid with tid=6 two cycles after the accept.
REQ-038 Assert rst during WCTRL -> ctrl_we=0 the next cycle, busy_vec=0, no response generated; LUTRAMPROT=1 parity checked on every write.
